// File: rtl/alu_multicycle.sv
// alu_multicycle: EX-stage ALU with registered outputs plus an iterative
// unsigned multiply/divide unit (HI/LO) behind a start/busy/done handshake.
// Single-cycle operations complete at the issuing edge. MULTU and DIVU
// take WIDTH cycles, processing one bit per cycle.
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] read1,
    input  logic [WIDTH-1:0] read2,
    input  logic [3:0]       control,
    input  logic             start,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_MULTU = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MFHI  = 4'b1000;
    localparam logic [3:0] OP_MFLO  = 4'b1001;
    localparam logic [3:0] OP_NOR   = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Iteration registers, shared between multiply and divide:
    //   MUL: acc = partial product upper half, opa = multiplier shifting
    //        out / product lower half shifting in, opb = multiplicand.
    //   DIV: acc = partial remainder, opa = dividend shifting out /
    //        quotient shifting in, opb = divisor.
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic [WIDTH-1:0] opa, opa_nxt;
    logic [WIDTH-1:0] opb, opb_nxt;

    logic [WIDTH-1:0] result_nxt, hi_nxt, lo_nxt;
    logic             zero_nxt, busy_nxt, done_nxt;

    logic             accept;
    logic             last_iter;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;

    // Combinational result of the single-cycle operations.
    function automatic logic [WIDTH-1:0] alu_single(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] hv,
        input logic [WIDTH-1:0] lv
    );
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        sa = signed'(a);
        sb = signed'(b);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLT:  return (sa < sb) ? WIDTH'(1) : '0;
            OP_NOR:  return ~(a | b);
            OP_MFHI: return hv;
            OP_MFLO: return lv;
            default: return '0;
        endcase
    endfunction

    // A start is only taken while no iterative operation is running.
    assign accept    = start && (state == S_IDLE);
    assign last_iter = (cnt == CNT_W'(1));

    // Shift-add step: add the multiplicand when the current multiplier bit
    // is set. The carry is kept so the right shift loses nothing.
    assign mul_sum   = {1'b0, acc} + (opa[0] ? {1'b0, opb} : '0);

    // Restoring-division step: bring in the next dividend bit and test
    // whether the divisor fits. A zero divisor always fits, which yields an
    // all-ones quotient and leaves the dividend as the remainder.
    assign div_shift = {acc, opa[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opb});

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: leave IDLE on an accepted MULTU/DIVU, return on
    // the last iteration.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept && control == OP_MULTU) begin
                    state_nxt = S_MUL;
                end else if (accept && control == OP_DIVU) begin
                    state_nxt = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (last_iter) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output and datapath next values for the current state.
    always_comb begin
        cnt_nxt    = cnt;
        acc_nxt    = acc;
        opa_nxt    = opa;
        opb_nxt    = opb;
        result_nxt = result;
        zero_nxt   = zero;
        hi_nxt     = hi;
        lo_nxt     = lo;
        busy_nxt   = busy;
        done_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    zero_nxt = (read1 == read2);
                    if (control == OP_MULTU) begin
                        acc_nxt  = '0;
                        opa_nxt  = read2;
                        opb_nxt  = read1;
                        cnt_nxt  = CNT_W'(WIDTH);
                        busy_nxt = 1'b1;
                    end else if (control == OP_DIVU) begin
                        acc_nxt  = '0;
                        opa_nxt  = read1;
                        opb_nxt  = read2;
                        cnt_nxt  = CNT_W'(WIDTH);
                        busy_nxt = 1'b1;
                    end else begin
                        result_nxt = alu_single(control, read1, read2, hi, lo);
                        done_nxt   = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_nxt = mul_sum[WIDTH:1];
                opa_nxt = {mul_sum[0], opa[WIDTH-1:1]};
                cnt_nxt = cnt - CNT_W'(1);
                if (last_iter) begin
                    hi_nxt     = acc_nxt;
                    lo_nxt     = opa_nxt;
                    result_nxt = opa_nxt;
                    done_nxt   = 1'b1;
                    busy_nxt   = 1'b0;
                end
            end
            S_DIV: begin
                acc_nxt = div_ge ? WIDTH'(div_shift - {1'b0, opb})
                                 : div_shift[WIDTH-1:0];
                opa_nxt = {opa[WIDTH-2:0], div_ge};
                cnt_nxt = cnt - CNT_W'(1);
                if (last_iter) begin
                    hi_nxt     = acc_nxt;
                    lo_nxt     = opa_nxt;
                    result_nxt = opa_nxt;
                    done_nxt   = 1'b1;
                    busy_nxt   = 1'b0;
                end
            end
            default: begin
                busy_nxt = 1'b0;
            end
        endcase
    end

    // Output and iteration registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            acc    <= '0;
            opa    <= '0;
            opb    <= '0;
            result <= '0;
            zero   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            acc    <= acc_nxt;
            opa    <= opa_nxt;
            opb    <= opb_nxt;
            result <= result_nxt;
            zero   <= zero_nxt;
            hi     <= hi_nxt;
            lo     <= lo_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Testbench for alu_multicycle (WIDTH=32): directed and randomized
// operations checked against a behavioural model of the ALU and HI/LO.
module tb_alu_multicycle;

    localparam int W = 32;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_MULTU = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MFHI  = 4'b1000;
    localparam logic [3:0] OP_MFLO  = 4'b1001;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_BAD   = 4'b0101;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] read1 = '0;
    logic [W-1:0] read2 = '0;
    logic [3:0]   control = '0;
    logic         start = 1'b0;
    logic [W-1:0] result;
    logic         zero;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int tests = 0;
    int fails = 0;

    // Reference HI/LO state.
    logic [W-1:0] mhi = '0;
    logic [W-1:0] mlo = '0;

    alu_multicycle #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .read1(read1), .read2(read2),
        .control(control), .start(start), .result(result), .zero(zero),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural model of single-cycle results.
    function automatic logic [W-1:0] model_single(input logic [3:0] op,
                                                 input logic [W-1:0] a,
                                                 input logic [W-1:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_ADD:  return W'((longint'(a) + longint'(b)) % (64'd1 << W));
            OP_SUB:  return W'(longint'(a) - longint'(b));
            OP_SLT:  return (sa < sb) ? 1 : 0;
            OP_NOR:  return ~(a | b);
            OP_MFHI: return mhi;
            OP_MFLO: return mlo;
            default: return '0;
        endcase
    endfunction

    // Behavioural model of MULTU/DIVU, updating the reference HI/LO.
    task automatic model_muldiv(input logic [3:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b);
        longint unsigned p;
        if (op == OP_MULTU) begin
            p = longint'(a) * longint'(b);
            mhi = p[63:32];
            mlo = p[31:0];
        end else if (b == 0) begin
            mlo = '1;
            mhi = a;
        end else begin
            mlo = a / b;
            mhi = a % b;
        end
    endtask

    // Present an operation for one edge; called and returns at a negedge.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        control = op;
        read1   = a;
        read2   = b;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Wait (bounded) until busy drops; report cycles and any busy/done overlap.
    task automatic wait_idle(output int cycles, output bit overlap);
        cycles  = 0;
        overlap = 1'b0;
        while (busy && cycles < 200) begin
            @(negedge clk);
            cycles++;
            if (busy && done) overlap = 1'b1;
        end
    endtask

    task automatic test_reset;
        #1;
        tests++; if ({result, zero, busy, done, hi, lo} !== '0) begin
            fails++; $display("FAIL reset_init: got result=%h zero=%b busy=%b done=%b hi=%h lo=%h, want all 0",
                              result, zero, busy, done, hi, lo);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        issue(OP_ADD, 32'd3, 32'd3);
        tests++; if (result !== 32'd6 || zero !== 1'b1 || done !== 1'b1) begin
            fails++; $display("FAIL reset_pre_add: got result=%h zero=%b done=%b, want 6/1/1", result, zero, done);
        end
        #2 reset = 1'b1;
        #1;
        tests++; if ({result, zero, busy, done, hi, lo} !== '0) begin
            fails++; $display("FAIL reset_async: got result=%h zero=%b busy=%b done=%b, want all 0",
                              result, zero, busy, done);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_add_sub;
        issue(OP_ADD, 32'hFFFFFFFF, 32'h1);
        tests++; if (result !== 32'h0 || zero !== 1'b0 || done !== 1'b1) begin
            fails++; $display("FAIL add_wrap: got result=%h zero=%b done=%b, want 0/0/1", result, zero, done);
        end
        @(negedge clk);
        tests++; if (done !== 1'b0) begin
            fails++; $display("FAIL add_done_pulse: got done=%b, want 0", done);
        end
        issue(OP_SUB, 32'd5, 32'd5);
        tests++; if (result !== 32'h0 || zero !== 1'b1) begin
            fails++; $display("FAIL sub_equal: got result=%h zero=%b, want 0/1", result, zero);
        end
    endtask

    task automatic test_slt_logic;
        issue(OP_SLT, 32'hFFFFFFFF, 32'h1);
        tests++; if (result !== 32'd1) begin
            fails++; $display("FAIL slt_neg_lt_pos: got %h want 1", result);
        end
        issue(OP_SLT, 32'h1, 32'hFFFFFFFF);
        tests++; if (result !== 32'd0) begin
            fails++; $display("FAIL slt_pos_lt_neg: got %h want 0", result);
        end
        issue(OP_AND, 32'hF0F0F0F0, 32'hFF00FF00);
        tests++; if (result !== 32'hF000F000) begin
            fails++; $display("FAIL and: got %h want f000f000", result);
        end
        issue(OP_NOR, 32'h0, 32'h0);
        tests++; if (result !== 32'hFFFFFFFF || zero !== 1'b1) begin
            fails++; $display("FAIL nor_zero: got result=%h zero=%b want ffffffff/1", result, zero);
        end
        issue(OP_BAD, 32'h1234, 32'h5678);
        tests++; if (result !== 32'h0 || done !== 1'b1 || hi !== mhi || lo !== mlo) begin
            fails++; $display("FAIL undefined_op: got result=%h done=%b hi=%h lo=%h want 0/1/%h/%h",
                              result, done, hi, lo, mhi, mlo);
        end
    endtask

    task automatic test_multu;
        int  cyc;
        bit  ov;
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        tests++; if (busy !== 1'b1 || done !== 1'b0) begin
            fails++; $display("FAIL multu_issue: got busy=%b done=%b want 1/0", busy, done);
        end
        wait_idle(cyc, ov);
        model_muldiv(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        tests++; if (cyc !== 32 || ov !== 1'b0) begin
            fails++; $display("FAIL multu_busy_len: got cycles=%0d overlap=%b want 32/0", cyc, ov);
        end
        tests++; if (hi !== 32'hFFFFFFFE || lo !== 32'h1 || result !== 32'h1 || done !== 1'b1) begin
            fails++; $display("FAIL multu_max: got hi=%h lo=%h result=%h done=%b want fffffffe/1/1/1",
                              hi, lo, result, done);
        end
        issue(OP_MFHI, 32'h0, 32'h0);
        tests++; if (result !== mhi || done !== 1'b1) begin
            fails++; $display("FAIL mfhi_after_done: got result=%h done=%b want %h/1", result, done, mhi);
        end
        @(negedge clk);
        tests++; if (done !== 1'b0) begin
            fails++; $display("FAIL mfhi_done_pulse: got done=%b want 0", done);
        end
    endtask

    task automatic test_divu;
        int  cyc;
        bit  ov;
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_idle(cyc, ov);
        model_muldiv(OP_DIVU, 32'd100, 32'd7);
        tests++; if (cyc !== 32 || lo !== 32'd14 || hi !== 32'd2 || result !== 32'd14 || done !== 1'b1) begin
            fails++; $display("FAIL divu_100_7: got cycles=%0d lo=%h hi=%h result=%h done=%b want 32/e/2/e/1",
                              cyc, lo, hi, result, done);
        end
        @(negedge clk);
        issue(OP_DIVU, 32'd9, 32'd0);
        wait_idle(cyc, ov);
        model_muldiv(OP_DIVU, 32'd9, 32'd0);
        tests++; if (cyc !== 32 || lo !== 32'hFFFFFFFF || hi !== 32'd9) begin
            fails++; $display("FAIL divu_by_zero: got cycles=%0d lo=%h hi=%h want 32/ffffffff/9", cyc, lo, hi);
        end
        issue(OP_MFLO, 32'h0, 32'h0);
        tests++; if (result !== 32'hFFFFFFFF) begin
            fails++; $display("FAIL mflo_after_div: got %h want ffffffff", result);
        end
    endtask

    task automatic test_single_random;
        logic [3:0]   ops [9] = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_MFHI, OP_MFLO, OP_BAD};
        logic [3:0]   op;
        logic [W-1:0] a, b, exp;
        for (int i = 0; i < 60; i++) begin
            op  = ops[$urandom_range(0, 8)];
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
            exp = model_single(op, a, b);
            issue(op, a, b);
            tests++; if (result !== exp || zero !== (a == b) || done !== 1'b1 || busy !== 1'b0) begin
                fails++; $display("FAIL single_rand op=%b a=%h b=%h: got result=%h zero=%b done=%b busy=%b want %h/%b/1/0",
                                  op, a, b, result, zero, done, busy, exp, a == b);
            end
        end
    endtask

    task automatic test_muldiv_random;
        int           cyc;
        bit           ov;
        logic [3:0]   op;
        logic [W-1:0] a, b;
        for (int i = 0; i < 12; i++) begin
            op = (i % 2 == 0) ? OP_MULTU : OP_DIVU;
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'h0;
                1:       b = $urandom_range(1, 300);
                default: b = $urandom;
            endcase
            issue(op, a, b);
            wait_idle(cyc, ov);
            model_muldiv(op, a, b);
            tests++; if (cyc !== 32 || ov !== 1'b0 || hi !== mhi || lo !== mlo || result !== mlo ||
                         done !== 1'b1 || zero !== (a == b)) begin
                fails++; $display("FAIL muldiv_rand op=%b a=%h b=%h: got cyc=%0d hi=%h lo=%h result=%h done=%b want 32/%h/%h/%h/1",
                                  op, a, b, cyc, hi, lo, result, done, mhi, mlo, mlo);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_busy;
        int           cyc;
        bit           ov;
        logic [W-1:0] a, b;
        a = $urandom;
        b = $urandom;
        issue(OP_MULTU, a, b);
        for (int i = 0; i < 10; i++) begin
            control = OP_ADD;
            read1   = $urandom;
            read2   = read1;
            start   = (i % 2 == 0);
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle(cyc, ov);
        model_muldiv(OP_MULTU, a, b);
        tests++; if (hi !== mhi || lo !== mlo || result !== mlo || zero !== (a == b) || done !== 1'b1) begin
            fails++; $display("FAIL ignore_busy: got hi=%h lo=%h result=%h zero=%b done=%b want %h/%h/%h/%b/1",
                              hi, lo, result, zero, done, mhi, mlo, mlo, a == b);
        end
        @(negedge clk);
        tests++; if (done !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL ignore_busy_no_queue: got done=%b busy=%b want 0/0", done, busy);
        end
    endtask

    task automatic test_back_to_back;
        int           cyc;
        bit           ov;
        logic [W-1:0] a, b, c, d;
        a = $urandom; b = $urandom; c = $urandom; d = $urandom_range(1, 1000);
        issue(OP_MULTU, a, b);
        wait_idle(cyc, ov);
        model_muldiv(OP_MULTU, a, b);
        issue(OP_DIVU, c, d);
        tests++; if (busy !== 1'b1 || done !== 1'b0 || hi !== mhi || lo !== mlo) begin
            fails++; $display("FAIL b2b_accept: got busy=%b done=%b hi=%h lo=%h want 1/0/%h/%h",
                              busy, done, hi, lo, mhi, mlo);
        end
        wait_idle(cyc, ov);
        model_muldiv(OP_DIVU, c, d);
        tests++; if (cyc !== 32 || hi !== mhi || lo !== mlo || done !== 1'b1) begin
            fails++; $display("FAIL b2b_divu: got cyc=%0d hi=%h lo=%h done=%b want 32/%h/%h/1",
                              cyc, hi, lo, done, mhi, mlo);
        end
        @(negedge clk);
    endtask

    task automatic test_abort;
        bit saw_done;
        issue(OP_DIVU, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        mhi = '0;
        mlo = '0;
        tests++; if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || result !== 32'h0) begin
            fails++; $display("FAIL abort_reset: got busy=%b done=%b hi=%h lo=%h result=%h want all 0",
                              busy, done, hi, lo, result);
        end
        @(negedge clk);
        reset = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        tests++; if (saw_done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            fails++; $display("FAIL abort_no_done: got activity=%b hi=%h lo=%h want 0/0/0", saw_done, hi, lo);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_slt_logic();
        test_multu();
        test_divu();
        test_single_random();
        test_muldiv_random();
        test_single_random();
        test_ignore_busy();
        test_back_to_back();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
